rl_ram_1r1w_fifo_ctrl: RTL and testbench



---
 rtl/rl_ram_1r1w_fifo_ctrl_if.sv | 34 +++
 rtl/rl_ram_1r1w_fifo_ctrl.sv | 111 +++++++++++
 tb/tb_rl_ram_1r1w_fifo_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rl_ram_1r1w_fifo_ctrl_if.sv
// Producer/consumer and block-RAM port bundle of rl_ram_1r1w_fifo_ctrl.
// slave = the FIFO controller, master = the environment (producer, consumer, RAM).
interface rl_ram_1r1w_fifo_ctrl_if #(
   parameter int ABITS = 10,
   parameter int DBITS = 32
);
   logic                   clr_i;
   logic                   push_i;
   logic [DBITS-1:0]       din_i;
   logic                   full_o;
   logic [DBITS-1:0]       dout_o;
   logic                   valid_o;
   logic                   ready_i;
   logic [ABITS+1:0]       cnt_o;
   logic                   ovf_o;
   logic [ABITS-1:0]       ram_waddr_o;
   logic [DBITS-1:0]       ram_din_o;
   logic                   ram_we_o;
   logic [(DBITS+7)/8-1:0] ram_be_o;
   logic [ABITS-1:0]       ram_raddr_o;
   logic [DBITS-1:0]       ram_dout_i;

   modport slave (
      input  clr_i, push_i, din_i, ready_i, ram_dout_i,
      output full_o, dout_o, valid_o, cnt_o, ovf_o,
             ram_waddr_o, ram_din_o, ram_we_o, ram_be_o, ram_raddr_o
   );

   modport master (
      output clr_i, push_i, din_i, ready_i, ram_dout_i,
      input  full_o, dout_o, valid_o, cnt_o, ovf_o,
             ram_waddr_o, ram_din_o, ram_we_o, ram_be_o, ram_raddr_o
   );
endinterface

// File: rtl/rl_ram_1r1w_fifo_ctrl.sv
// FIFO controller over an external 1R1W block RAM with a 2-entry FWFT output stage.
// Define RL_FIFO_OVERFLOW_CHK_EN to make ovf_o a sticky push-while-full flag.
module rl_ram_1r1w_fifo_ctrl #(
   parameter int ABITS = 10,
   parameter int DBITS = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   rl_ram_1r1w_fifo_ctrl_if.slave bus
);
   localparam int DEPTH = 1 << ABITS;

   typedef logic [ABITS:0] ptr_t;

   ptr_t             wp_q, wp_d, rp_q, rp_d;
   logic             full_q, full_d;
   logic             inflight_q, inflight_d;
   logic [1:0]       out_cnt_q, out_cnt_d;
   logic [DBITS-1:0] head_q, head_d, skid_q, skid_d;
   logic [ABITS-1:0] raddr_q, raddr_d;
   logic             ovf_q, ovf_d;

   ptr_t             ram_cnt, ram_cnt_d;
   logic             push_ok, pop, issue;
   logic [1:0]       out_left;

   // out_left is the output-stage occupancy once this cycle's pop is taken.
   always_comb begin
      ram_cnt  = wp_q - rp_q;
      push_ok  = bus.push_i && !full_q && !bus.clr_i;
      pop      = (out_cnt_q != 2'd0) && bus.ready_i && !bus.clr_i;
      out_left = out_cnt_q - {1'b0, pop};
      issue    = !bus.clr_i && (ram_cnt != '0) && ((out_left + {1'b0, inflight_q}) < 2'd2);
   end

   // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
   always_comb begin
      wp_d       = wp_q + {{ABITS{1'b0}}, push_ok};
      rp_d       = rp_q + {{ABITS{1'b0}}, issue};
      inflight_d = issue;
      out_cnt_d  = out_left + {1'b0, inflight_q};
      head_d     = head_q;
      skid_d     = skid_q;
      raddr_d    = issue ? rp_q[ABITS-1:0] : raddr_q;

      if (pop && (out_cnt_q == 2'd2)) head_d = skid_q;
      // A returning word lands behind whatever survives the pop, so no bubble.
      if (inflight_q) begin
         if (out_left == 2'd0) head_d = bus.ram_dout_i;
         else                  skid_d = bus.ram_dout_i;
      end

      if (bus.clr_i) begin
         wp_d       = '0;
         rp_d       = '0;
         inflight_d = 1'b0;
         out_cnt_d  = 2'd0;
      end

      ram_cnt_d = wp_d - rp_d;
      full_d    = (ram_cnt_d == ptr_t'(DEPTH));
   end

`ifdef RL_FIFO_OVERFLOW_CHK_EN
   assign ovf_d = ovf_q | (bus.push_i && full_q && !bus.clr_i);

   overflow_chk: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bus.push_i && full_q && !bus.clr_i))
      else $error("rl_ram_1r1w_fifo_ctrl: push while full dropped");
`else
   assign ovf_d = 1'b0;
`endif

   // NOTE: state updates use non-blocking assignments; the data registers are reset too since dout_o must read 0 out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wp_q       <= '0;
         rp_q       <= '0;
         full_q     <= 1'b0;
         inflight_q <= 1'b0;
         out_cnt_q  <= 2'd0;
         head_q     <= '0;
         skid_q     <= '0;
         raddr_q    <= '0;
         ovf_q      <= 1'b0;
      end else begin
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         full_q     <= full_d;
         inflight_q <= inflight_d;
         out_cnt_q  <= out_cnt_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
         raddr_q    <= raddr_d;
         ovf_q      <= ovf_d;
      end
   end

   assign bus.full_o      = full_q;
   assign bus.dout_o      = head_q;
   assign bus.valid_o     = (out_cnt_q != 2'd0);
   assign bus.cnt_o       = {1'b0, ram_cnt} + {{(ABITS+1){1'b0}}, inflight_q}
                          + {{ABITS{1'b0}}, out_cnt_q};
   assign bus.ovf_o       = ovf_q;
   // Gated by reset so a push held during reset never reaches the RAM.
   assign bus.ram_we_o    = push_ok && rst_ni;
   assign bus.ram_waddr_o = wp_q[ABITS-1:0];
   assign bus.ram_din_o   = bus.din_i;
   assign bus.ram_be_o    = '1;
   assign bus.ram_raddr_o = raddr_d;
endmodule

// File: tb/tb_rl_ram_1r1w_fifo_ctrl.sv
// Self-checking bench for rl_ram_1r1w_fifo_ctrl (ABITS=3) with a behavioural RAM
// and a queue-based FIFO reference model.
module tb_rl_ram_1r1w_fifo_ctrl;
   localparam int ABITS = 3;
   localparam int DBITS = 32;
   localparam int DEPTH = 1 << ABITS;
`ifdef RL_FIFO_OVERFLOW_CHK_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   logic [DBITS-1:0] model_q[$];
   logic [DBITS-1:0] popped[$];
   logic [DBITS-1:0] sent[$];
   logic             ovf_exp = 1'b0;
   logic [DBITS-1:0] mem [DEPTH];

   rl_ram_1r1w_fifo_ctrl_if #(.ABITS(ABITS), .DBITS(DBITS)) bus ();

   rl_ram_1r1w_fifo_ctrl #(.ABITS(ABITS), .DBITS(DBITS)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Registered-read 1R1W RAM.
   always @(posedge clk) begin
      if (bus.ram_we_o) mem[bus.ram_waddr_o] <= bus.ram_din_o;
      bus.ram_dout_i <= mem[bus.ram_raddr_o];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Invariants that follow from the model queue alone.
   task automatic monitor();
      check("cnt_vs_model", bus.cnt_o, model_q.size());
      check("ovf", bus.ovf_o, ovf_exp);
      if (bus.valid_o) begin
         check("valid_nonempty", model_q.size() != 0, 1);
         if (model_q.size() != 0) check("dout_head", bus.dout_o, model_q[0]);
      end
      if (model_q.size() >= DEPTH + 2) check("full_at_max", bus.full_o, 1);
      if (model_q.size() < DEPTH)      check("not_full", bus.full_o, 0);
   endtask

   task automatic step(input logic p, input logic [DBITS-1:0] d, input logic r, input logic c);
      logic acc, pp;
      monitor();
      bus.push_i  = p;
      bus.din_i   = d;
      bus.ready_i = r;
      bus.clr_i   = c;
      acc = p && !bus.full_o && !c;
      pp  = bus.valid_o && r && !c;
      if (OVF_EN && p && bus.full_o && !c) ovf_exp = 1'b1;
      if (pp) popped.push_back(bus.dout_o);
      @(posedge clk);
      if (c) model_q.delete();
      else begin
         if (pp)  void'(model_q.pop_front());
         if (acc) model_q.push_back(d);
      end
      @(negedge clk);
   endtask

   task automatic reset_checks(input logic [DBITS-1:0] din_now);
      check("rst_valid", bus.valid_o, 0);
      check("rst_cnt",   bus.cnt_o, 0);
      check("rst_full",  bus.full_o, 0);
      check("rst_ovf",   bus.ovf_o, 0);
      check("rst_dout",  bus.dout_o, 0);
      check("rst_we",    bus.ram_we_o, 0);
      check("rst_waddr", bus.ram_waddr_o, 0);
      check("rst_raddr", bus.ram_raddr_o, 0);
      check("rst_be",    bus.ram_be_o, 4'hF);
      check("rst_din",   bus.ram_din_o, din_now);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int sent_n;
      int cyc;
      logic p;
      logic [DBITS-1:0] d;

      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      bus.ram_dout_i = '0;
      rst_n       = 1'b0;
      bus.push_i  = 1'b1;
      bus.din_i   = 32'h1234_5678;
      bus.ready_i = 1'b0;
      bus.clr_i   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_checks(32'h1234_5678);
      bus.push_i = 1'b0;
      rst_n      = 1'b1;
      @(negedge clk);

      // Fill: 10 words, 8 in RAM + 2 in output stage, then a dropped push.
      for (int i = 0; i < 10; i++) step(1'b1, DBITS'(i), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      check("fill_full", bus.full_o, 1);
      check("fill_cnt",  bus.cnt_o, 10);
      check("fill_valid", bus.valid_o, 1);
      check("fill_head", bus.dout_o, 0);
      step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      check("fill_ovf", bus.ovf_o, OVF_EN);
      check("drop_cnt", bus.cnt_o, 10);
      popped.delete();
      for (int i = 0; i < 14; i++) step(1'b0, '0, 1'b1, 1'b0);
      check("drain_n", popped.size(), 10);
      for (int i = 0; i < popped.size(); i++) check("drain_order", popped[i], i);
      check("drain_valid", bus.valid_o, 0);
      check("drain_cnt", bus.cnt_o, 0);

      // Flush with a read in flight and a push/pop presented.
      step(1'b1, 32'h0000_0A01, 1'b0, 1'b0);
      step(1'b1, 32'h0000_0A02, 1'b0, 1'b0);
      step(1'b1, 32'h0000_0A03, 1'b0, 1'b0);
      step(1'b1, 32'h0000_0A04, 1'b1, 1'b1);
      check("clr_valid", bus.valid_o, 0);
      check("clr_cnt",   bus.cnt_o, 0);
      check("clr_full",  bus.full_o, 0);
      check("clr_ovf_sticky", bus.ovf_o, OVF_EN);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         check("clr_no_stale", bus.valid_o, 0);
      end

      // Continuous push and pop.
      for (int i = 0; i < 100; i++) begin
         step(1'b1, $urandom, 1'b1, 1'b0);
         if (i >= 5) begin
            check("stream_valid", bus.valid_o, 1);
            check("stream_cnt", (bus.cnt_o == 2) || (bus.cnt_o == 3), 1);
         end
      end
      cyc = 0;
      while ((model_q.size() != 0) && (cyc < 50)) begin
         step(1'b0, '0, 1'b1, 1'b0);
         cyc++;
      end
      check("stream_drained", model_q.size(), 0);

      // Pointer wrap with random push/ready.
      popped.delete();
      sent.delete();
      sent_n = 0;
      cyc    = 0;
      while ((sent_n < 50) && (cyc < 2000)) begin
         p = ($urandom_range(0, 3) != 0);
         d = $urandom;
         if (p && !bus.full_o) begin
            sent_n++;
            sent.push_back(d);
         end
         step(p, d, 1'($urandom_range(0, 1)), 1'b0);
         cyc++;
      end
      check("wrap_sent", sent_n, 50);
      cyc = 0;
      while (((model_q.size() != 0) || bus.valid_o) && (cyc < 200)) begin
         step(1'b0, '0, 1'b1, 1'b0);
         cyc++;
      end
      check("wrap_n", popped.size(), 50);
      for (int i = 0; i < popped.size() && i < sent.size(); i++) check("wrap_order", popped[i], sent[i]);

      // Asynchronous reset mid-stream with five words held.
      for (int i = 0; i < 5; i++) step(1'b1, DBITS'(32'h100 + i), 1'b0, 1'b0);
      check("pre_rst_cnt", bus.cnt_o, 5);
      bus.push_i = 1'b1;
      bus.din_i  = 32'h0BAD_F00D;
      #2 rst_n = 1'b0;
      #1 reset_checks(32'h0BAD_F00D);
      model_q.delete();
      ovf_exp = 1'b0;
      @(negedge clk);
      bus.push_i = 1'b0;
      rst_n      = 1'b1;
      @(negedge clk);
      step(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
      check("lat_e0", bus.valid_o, 0);
      step(1'b0, '0, 1'b0, 1'b0);
      check("lat_e1", bus.valid_o, 0);
      step(1'b0, '0, 1'b0, 1'b0);
      check("lat_e2", bus.valid_o, 1);
      check("lat_dout", bus.dout_o, 32'hA5A5_A5A5);
      monitor();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
